// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer: WORDS x 32-bit operands, one word per cycle through a shared carry-skip adder.
// Optional signed-overflow output enabled by defining MPADD_OVF_EN.

module carry_skip_adder #(
    parameter int W   = 32,
    parameter int BLK = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic [W-1:0] sum_c;
    logic         carry_c;
    logic         ripple_c;
    logic         prop_c;

    // NOTE: blocking assignments are intended here; the carry variables are
    // evaluated in order within one pass, and every variable is defaulted
    // first so no latch is inferred.
    always_comb begin
        sum_c    = '0;
        carry_c  = cin_i;
        ripple_c = 1'b0;
        prop_c   = 1'b0;
        for (int blk = 0; blk < W / BLK; blk++) begin
            ripple_c = carry_c;
            prop_c   = 1'b1;
            for (int k = 0; k < BLK; k++) begin
                sum_c[blk*BLK+k] = a_i[blk*BLK+k] ^ b_i[blk*BLK+k] ^ ripple_c;
                ripple_c = (a_i[blk*BLK+k] & b_i[blk*BLK+k]) |
                           (ripple_c & (a_i[blk*BLK+k] ^ b_i[blk*BLK+k]));
                prop_c   = prop_c & (a_i[blk*BLK+k] ^ b_i[blk*BLK+k]);
            end
            // A fully propagating block forwards its incoming carry unchanged.
            carry_c = prop_c ? carry_c : ripple_c;
        end
    end

    assign sum_o  = sum_c;
    assign cout_o = carry_c;

endmodule

module mp_add_sequencer #(
    parameter int WORDS = 4,
    parameter int W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               op_sub,
    input  logic [WORDS*W-1:0] a,
    input  logic [WORDS*W-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORDS*W-1:0] sum,
    output logic               cout
`ifdef MPADD_OVF_EN
   ,output logic               ovf
`endif
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    if (W != 32) begin : g_bad_width
        $error("mp_add_sequencer: W must be 32");
    end
    if (WORDS < 2 || WORDS > 16) begin : g_bad_words
        $error("mp_add_sequencer: WORDS must be in 2..16");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e             state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [WORDS*W-1:0] a_q;
    logic [WORDS*W-1:0] b_q;
    logic               sub_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [WORDS*W-1:0] sum_q;
    logic               cout_q;
`ifdef MPADD_OVF_EN
    logic               ovf_q;
`endif

    logic [W-1:0] a_word_d;
    logic [W-1:0] b_word_d;
    logic [W-1:0] word_sum_d;
    logic         word_cout_d;

    // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
    assign a_word_d = a_q[idx_q*W +: W];
    assign b_word_d = b_q[idx_q*W +: W] ^ {W{sub_q}};

    carry_skip_adder #(
        .W   (W),
        .BLK (4)
    ) u_adder (
        .a_i    (a_word_d),
        .b_i    (b_word_d),
        .cin_i  (carry_q),
        .sum_o  (word_sum_d),
        .cout_o (word_cout_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            // NOTE: the wide operand and result registers are reset too, so an
            // aborted operation leaves no stale data visible on sum.
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
`ifdef MPADD_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        sub_q      <= op_sub;
                        idx_q      <= '0;
                        carry_q    <= op_sub;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q[idx_q*W +: W] <= word_sum_d;
                    carry_q             <= word_cout_d;
                    idx_q               <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= word_cout_d;
`ifdef MPADD_OVF_EN
                        ovf_q       <= (a_word_d[W-1] == b_word_d[W-1]) &&
                                       (word_sum_d[W-1] != a_word_d[W-1]);
`endif
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef MPADD_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: doc/mp_add_sequencer.md
Name: mp_add_sequencer

Overview:
Multi-precision add/subtract sequencer built around one shared 32-bit `carry_skip_adder` instance.
- Accepts WORDS×32-bit operands through a valid/ready handshake.
- Processes one 32-bit word per cycle, LSW first, chaining the carry through a register.
- Presents the full-width result through a valid/ready handshake.
- Serves as the wide-integer front end that feeds the FP add/sub mantissa path.

Parameters:
- WORDS, 4, number of 32-bit words per operand; legal range 2..16.
- W, 32, word width; fixed to 32 to match `carry_skip_adder`; any other value is unsupported.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept operands.
- op_sub  in  1  0 = a+b, 1 = a−b; sampled with the operands.
- a  in  WORDS*W  operand A, word 0 = bits [31:0].
- b  in  WORDS*W  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WORDS*W  result, registered.
- cout  out  1  final carry out of the MSW; for subtract, 1 = no borrow (a ≥ b unsigned).

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, word index=0, carry reg=0, latched operands=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch a, b, op_sub; index←0; carry←op_sub; go to RUN.
- RUN:
  - in_ready=0. The adder is driven with a_word[idx], b_word[idx] XOR {32{op_sub}}, cin = carry reg.
  - Each cycle: sum_word[idx]←adder sum; carry←adder cout; idx←idx+1.
  - When idx==WORDS−1: cout←adder cout; go to DONE.
- DONE:
  - out_valid=1; sum and cout held stable; in_ready=0.
  - On out_ready: out_valid←0; go to IDLE.
- Latency: accept at edge N → out_valid high after edge N+WORDS. Throughput is one operation per WORDS+2 cycles minimum, because in_ready is asserted only in IDLE.
- The adder is combinational and sits between registers. It has no path from inputs to outputs in the same cycle.
- in_valid while in_ready=0 is ignored; no queuing. Operand inputs may change freely after acceptance.
- out_valid is held with stable data under backpressure for any duration.
- Result register words not yet written during RUN keep their previous value. sum is only meaningful when out_valid=1.
- Reset mid-RUN or mid-DONE aborts the operation; the partial result is discarded and zeroed.
- Arithmetic wraps modulo 2^(WORDS*32); no saturation.

Optional Feature:
- Macro: MPADD_OVF_EN.
- Defined:
  - Adds output port ovf (out, 1 bit): two's-complement signed overflow of the full-width result.
  - Computed in the final RUN cycle as (a_msb == beff_msb) & (sum_msb != a_msb), where beff = b XOR {op_sub}.
  - Registered with cout and held in DONE; reset value 0.
- Not defined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
1. WORDS=4, add, a=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, b=1 → sum=0x..._0000_0001_0000_0000, cout=0. out_valid rises exactly 4 cycles after the accept edge.
2. Add, a=all-ones (128 bits), b=1 → sum=0, cout=1. Also a=0, b=0 → sum=0, cout=0.
3. Subtract, a=5, b=7 → sum=0xFFFF…FFFE, cout=0. Then a=7, b=5 → sum=2, cout=1.
4. Backpressure: hold out_ready=0 for 3 cycles after out_valid → sum/cout stable, in_ready=0, a new in_valid pulse is ignored. Assert out_ready → out_valid=0 and in_ready=1 next cycle.
5. Assert rst asynchronously (mid-cycle) after 2 words processed in RUN → immediately out_valid=0, sum=0, in_ready=1. A fresh add 3+4 then yields 7.
6. With MPADD_OVF_EN defined:
   - 0x7FFF…FFFF + 1 → ovf=1.
   - 0x8000…0000 − 1 → ovf=1.
   - 5 − 7 → ovf=0.
